// File: rtl/dcache_mem_pkg.sv
// Shared types and size helpers for the Dcache memory responder.
package dcache_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_RESP
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = 8 * WORD_BYTES;
    localparam int BO         = $clog2(WORD_BYTES);

    localparam int LINE_WORDS_DEF = 4;
    localparam int LINE_W_DEF     = WORD_W * LINE_WORDS_DEF;
    localparam int CNT_W_DEF      = $clog2(LINE_WORDS_DEF) + 1;

    function automatic int cnt_w(int lw);
        return $clog2(lw) + 1;
    endfunction

    function automatic int off_w(int lw);
        return $clog2(lw) + BO;
    endfunction

    function automatic int line_w(int lw);
        return WORD_W * lw;
    endfunction

endpackage

// File: rtl/dcache_mem_wbuf.sv
// One-entry posted write buffer; a load wins over a drain in the same cycle.
module dcache_mem_wbuf
    import dcache_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  drain,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [WORD_W-1:0]     ld_data,
    input  logic [WORD_BYTES-1:0] ld_strb,
    output logic                  valid,
    output logic [ADDR_W-1:0]     addr,
    output logic [WORD_W-1:0]     data,
    output logic [WORD_BYTES-1:0] strb
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
            strb  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= ld_addr;
            data  <= ld_data;
            strb  <= ld_strb;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dcache_mem_responder.sv
// Dcache line-refill / write-through responder onto a req/gnt/rvalid RAM port.
// DCACHE_MEM_WBUF_EN enables the one-entry posted write buffer.
module dcache_mem_responder
    import dcache_mem_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dcache_mem_req,
    input  logic                         dcache_mem_wr,
    input  logic                         dcache_mem_uncached,
    input  logic [ADDR_W-1:0]            dcache_mem_addr,
    input  logic [31:0]                  dcache_mem_wdata,
    input  logic [3:0]                   dcache_mem_wstrb,
    output logic                         mem_dcache_addrOK,
    output logic                         mem_dcache_dataOK,
    output logic [32*LINE_WORDS-1:0]     mem_dcache_rdata,
    output logic                         ram_req,
    output logic                         ram_we,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic [31:0]                  ram_wdata,
    output logic [3:0]                   ram_wstrb,
    input  logic                         ram_gnt,
    input  logic                         ram_rvalid,
    input  logic [31:0]                  ram_rdata
);

    localparam int CW = cnt_w(LINE_WORDS);
    localparam int OW = off_w(LINE_WORDS);
    localparam int LW = line_w(LINE_WORDS);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [CW-1:0]     n_q, iss_q, rcv_q;
    logic              unc_q;
    logic [LINE_WORDS-1:0][WORD_W-1:0] line_q, line_nx;
    logic [LW-1:0]     rdata_q;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [31:0]       wb_data;
    logic [3:0]        wb_strb;
    logic              rd_acc, rd_issue, rd_last, wr_ok;
    logic [ADDR_W-1:0] wr_addr;
    logic              unused_addr;

    assign wr_addr     = {dcache_mem_addr[ADDR_W-1:BO], {BO{1'b0}}};
    assign unused_addr = ^dcache_mem_addr[BO-1:0];

`ifdef DCACHE_MEM_WBUF_EN
    logic wb_load;

    assign wb_load = dcache_mem_req & dcache_mem_wr
                   & (~wb_valid | ram_gnt) & ~rst;
    assign wr_ok   = wb_load;
    assign rd_acc  = (state_q == S_IDLE) & dcache_mem_req
                   & ~dcache_mem_wr & ~wb_valid & ~rst;

    dcache_mem_wbuf #(
        .ADDR_W (ADDR_W)
    ) u_wbuf (
        .clk     (clk),
        .rst     (rst),
        .load    (wb_load),
        .drain   (wb_valid & ram_gnt),
        .ld_addr (wr_addr),
        .ld_data (dcache_mem_wdata),
        .ld_strb (dcache_mem_wstrb),
        .valid   (wb_valid),
        .addr    (wb_addr),
        .data    (wb_data),
        .strb    (wb_strb)
    );
`else
    // Without a buffer the write itself occupies the RAM port from idle.
    assign wb_valid = (state_q == S_IDLE) & dcache_mem_req
                    & dcache_mem_wr & ~rst;
    assign wb_addr  = wr_addr;
    assign wb_data  = dcache_mem_wdata;
    assign wb_strb  = dcache_mem_wstrb;
    assign wr_ok    = wb_valid & ram_gnt;
    assign rd_acc   = (state_q == S_IDLE) & dcache_mem_req
                    & ~dcache_mem_wr & ~rst;
`endif

    assign rd_issue = (state_q == S_RD) & (iss_q < n_q) & ~wb_valid;
    assign rd_last  = (state_q == S_RD) & ram_rvalid
                    & (rcv_q + CW'(1) == n_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (rd_acc)  state_d = S_RD;
            S_RD:    if (rd_last) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_req   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wstrb = '0;
        if (wb_valid) begin
            ram_req   = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = wb_addr;
            ram_wdata = wb_data;
            ram_wstrb = wb_strb;
        end else if (rd_issue) begin
            ram_req  = 1'b1;
            ram_addr = base_q + (ADDR_W'(iss_q) << BO);
        end
        mem_dcache_addrOK = rd_acc | wr_ok;
        mem_dcache_dataOK = (state_q == S_RESP);
    end

    always_comb begin
        line_nx = line_q;
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (ram_rvalid && rcv_q == CW'(i)) line_nx[i] = ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            n_q     <= '0;
            iss_q   <= '0;
            rcv_q   <= '0;
            unc_q   <= 1'b0;
            line_q  <= '0;
            rdata_q <= '0;
        end else if (rd_acc) begin
            base_q <= dcache_mem_uncached ? wr_addr
                    : {dcache_mem_addr[ADDR_W-1:OW], {OW{1'b0}}};
            n_q    <= dcache_mem_uncached ? CW'(1) : CW'(LINE_WORDS);
            iss_q  <= '0;
            rcv_q  <= '0;
            unc_q  <= dcache_mem_uncached;
        end else if (state_q == S_RD) begin
            if (rd_issue && ram_gnt) iss_q <= iss_q + CW'(1);
            if (ram_rvalid)          rcv_q <= rcv_q + CW'(1);
            line_q <= line_nx;
            // Output line only changes on completion so it holds between reads.
            if (rd_last) rdata_q <= unc_q ? LW'(line_nx[0]) : line_nx;
        end
    end

    assign mem_dcache_rdata = rdata_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Randomized bench for dcache_mem_responder against a RAM model and a word-level memory reference.
module tb_dcache_mem_responder;

    localparam int LINE_WORDS = 4;
    localparam int ADDR_W     = 32;
    localparam int LW         = 32 * LINE_WORDS;
`ifdef DCACHE_MEM_WBUF_EN
    localparam int WB_DLY = 1;
`else
    localparam int WB_DLY = 0;
`endif

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0, wr = 1'b0, unc = 1'b0;
    logic [31:0]   addr = '0, wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          addr_ok, data_ok;
    logic [LW-1:0] rdata;
    logic          ram_req, ram_we;
    logic [31:0]   ram_addr, ram_wdata;
    logic [3:0]    ram_wstrb;
    logic          ram_gnt = 1'b0, ram_rvalid = 1'b0;
    logic [31:0]   ram_rdata = '0;

    acc_t        acc_log[$];
    logic [31:0] pend[$];
    logic [31:0] ram_mem[int unsigned];
    logic [31:0] ref_mem[int unsigned];
    int          cyc = 0;
    int          gnt_low = 0;
    bit          rnd_mode = 1'b0;
    int          n_chk = 0, n_fail = 0;

    dcache_mem_responder #(
        .LINE_WORDS (LINE_WORDS),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .dcache_mem_req      (req),
        .dcache_mem_wr       (wr),
        .dcache_mem_uncached (unc),
        .dcache_mem_addr     (addr),
        .dcache_mem_wdata    (wdata),
        .dcache_mem_wstrb    (wstrb),
        .mem_dcache_addrOK   (addr_ok),
        .mem_dcache_dataOK   (data_ok),
        .mem_dcache_rdata    (rdata),
        .ram_req             (ram_req),
        .ram_we              (ram_we),
        .ram_addr            (ram_addr),
        .ram_wdata           (ram_wdata),
        .ram_wstrb           (ram_wstrb),
        .ram_gnt             (ram_gnt),
        .ram_rvalid          (ram_rvalid),
        .ram_rdata           (ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [LW-1:0] got, logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d,
                                          logic [3:0] s);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Unwritten memory reads back its own word address.
    function automatic logic [31:0] ram_rd(logic [31:0] a);
        int unsigned k = a >> 2;
        if (ram_mem.exists(k)) return ram_mem[k];
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        int unsigned k = a >> 2;
        if (ref_mem.exists(k)) return ref_mem[k];
        return {a[31:2], 2'b00};
    endfunction

    // Pipelined RAM: reads return in order, at least one cycle after gnt.
    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
        end else if (ram_req && ram_gnt) begin
            acc_log.push_back('{cyc, ram_we, ram_addr, ram_wdata, ram_wstrb});
            if (ram_we) ram_mem[ram_addr >> 2] = merge(ram_rd(ram_addr), ram_wdata, ram_wstrb);
            else        pend.push_back(ram_rd(ram_addr));
        end
        cyc++;
        #2;
        if (gnt_low > 0) begin
            ram_gnt = 1'b0;
            gnt_low--;
        end else begin
            ram_gnt = rnd_mode ? ($urandom_range(3) != 0) : 1'b1;
        end
        if (pend.size() > 0 && (!rnd_mode || $urandom_range(2) != 0)) begin
            ram_rvalid = 1'b1;
            ram_rdata  = pend.pop_front();
        end else begin
            ram_rvalid = 1'b0;
            ram_rdata  = $urandom;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) nxt();
    endtask

    task automatic chk_zero(string p);
        @(negedge clk);
        chk({p, "_addrok"}, addr_ok, 0);
        chk({p, "_dataok"}, data_ok, 0);
        chk({p, "_rdata"}, rdata, 0);
        chk({p, "_ram_req"}, ram_req, 0);
        chk({p, "_ram_we"}, ram_we, 0);
        chk({p, "_ram_addr"}, ram_addr, 0);
        chk({p, "_ram_wdata"}, ram_wdata, 0);
        chk({p, "_ram_wstrb"}, ram_wstrb, 0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int lat, output int acc_o);
        int st = cyc;
        acc_o = -1;
        req = 1'b1; wr = 1'b1; unc = 1'b0;
        addr = a; wdata = d; wstrb = s;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (addr_ok) acc_o = cyc;
            nxt();
            if (acc_o >= 0) break;
        end
        req = 1'b0; wr = 1'b0;
        chk("wr_acc", acc_o >= 0, 1);
        lat = acc_o - st;
        if (acc_o >= 0) ref_mem[a >> 2] = merge(ref_rd(a), d, s);
    endtask

    task automatic do_read(input logic [31:0] a, input bit u, input bit hold,
                           output int acc_o, output int first_o);
        int            n = u ? 1 : LINE_WORDS;
        logic [31:0]   base;
        logic [LW-1:0] exp = '0;
        logic [LW-1:0] got = 'x;
        int            dok_c = -1, dok_n = 0, st = acc_log.size();
        logic [31:0]   rd_q[$];
        int            rd_c[$];
        base = u ? {a[31:2], 2'b00} : (a & ~32'(LINE_WORDS * 4 - 1));
        for (int i = 0; i < n; i++) exp[32*i +: 32] = ref_rd(base + 32'(4 * i));
        acc_o = -1;
        first_o = -1;
        req = 1'b1; wr = 1'b0; unc = u; addr = a;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (acc_o < 0 && addr_ok) acc_o = cyc;
            if (data_ok) begin
                dok_n++;
                dok_c = cyc;
                got = rdata;
            end
            nxt();
            if (acc_o >= 0 && (!hold || dok_n > 0)) req = 1'b0;
            if (dok_n > 0 && cyc > dok_c + 3) break;
        end
        req = 1'b0; unc = 1'b0;
        for (int i = st; i < acc_log.size(); i++) begin
            if (!acc_log[i].we) begin
                rd_q.push_back(acc_log[i].addr);
                rd_c.push_back(acc_log[i].cyc);
            end
        end
        chk("rd_acc", acc_o >= 0, 1);
        chk("rd_dok_pulses", dok_n, 1);
        chk("rd_line", got, exp);
        chk("rd_nacc", rd_q.size(), n);
        for (int i = 0; i < rd_q.size() && i < n; i++)
            chk("rd_addr", rd_q[i], base + 32'(4 * i));
        if (rd_c.size() > 0) first_o = rd_c[0];
        if (!rnd_mode && acc_o >= 0) begin
            chk("rd_dok_lat", dok_c - acc_o, n + 2);
            chk("rd_iss_lat", first_o - acc_o, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        int lat, wac, rac, rfirst, wg, op;
        logic [31:0] a;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_zero("rst");
        nxt();

        do_read(32'h0000_1234, 1'b0, 1'b0, rac, rfirst);
        do_read(32'h0000_0088, 1'b1, 1'b0, rac, rfirst);

        idle(3);
        acc_log.delete();
        do_write(32'h40, 32'hDEAD_BEEF, 4'b0011, lat, wac);
        chk("wr_lat", lat, 0);
        idle(4);
        chk("wr_nacc", acc_log.size(), 1);
        if (acc_log.size() > 0) begin
            chk("wr_cyc", acc_log[0].cyc - wac, WB_DLY);
            chk("wr_we", acc_log[0].we, 1);
            chk("wr_addr", acc_log[0].addr, 32'h40);
            chk("wr_data", acc_log[0].wdata, 32'hDEAD_BEEF);
            chk("wr_strb", acc_log[0].strb, 4'b0011);
        end

        idle(3);
        gnt_low = 3;
        do_write(32'h83, 32'h1234_5678, 4'hF, lat, wac);
        do_read(32'h80, 1'b1, 1'b0, rac, rfirst);
        wg = -1;
        foreach (acc_log[i]) if (acc_log[i].we && acc_log[i].addr == 32'h80) wg = acc_log[i].cyc;
        chk("wb_drain_seen", wg >= 0, 1);
        chk("wb_rd_after_gnt", rac > wg, 1);
        chk("wb_rd_iss_after", rfirst > wg, 1);
`ifdef DCACHE_MEM_WBUF_EN
        chk("wb_rd_acc_cyc", rac - wg, 1);
`endif

        do_read(32'h0000_0300, 1'b0, 1'b1, rac, rfirst);

        idle(3);
        req = 1'b1; wr = 1'b0; unc = 1'b0; addr = 32'h200;
        @(negedge clk);
        chk("mr_acc", addr_ok, 1);
        nxt();
        req = 1'b0;
        nxt();
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        chk_zero("mr");
        nxt();
        do_read(32'h0000_0204, 1'b0, 1'b0, rac, rfirst);

        rnd_mode = 1'b1;
        for (int t = 0; t < 80; t++) begin
            op = $urandom_range(3);
            a  = 32'h1000 + $urandom_range(255);
            if (op < 2)
                do_write(a, $urandom, 4'($urandom_range(15, 1)), lat, wac);
            else
                do_read(a, op == 3, $urandom_range(1) == 1, rac, rfirst);
            idle($urandom_range(2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
